// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the FC feeder FSM encoding.
package lenet_pkg;

   localparam int LP_M     = 32;
   localparam int LP_MA    = 16;
   localparam int LP_N_F   = 12;
   localparam int LP_S_P_O = 4;
   localparam int FC_DEPTH = LP_N_F * LP_S_P_O * LP_S_P_O;

   typedef enum logic {
      FILL  = 1'b0,
      SERVE = 1'b1
   } fc_state_e;

endpackage : lenet_pkg

// File: rtl/fc_fmap_ram.sv
// Feature-map store: synchronous write, asynchronous read, contents never reset.
module fc_fmap_ram #(
   parameter int W     = 32,
   parameter int DEPTH = 192,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : fc_fmap_ram

// File: rtl/fc_feed.sv
// Collects one flattened pooled frame, then serves FC (row, column) reads
// until the FC result is acknowledged.
module fc_feed
   import lenet_pkg::*;
#(
   parameter int M     = LP_M,
   parameter int Ma    = LP_MA,
   parameter int N_f   = LP_N_F,
   parameter int S_P_o = LP_S_P_O
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pool_valid,
   input  logic [M-1:0]  pool_data,
   output logic          pool_ready,
   output logic          fc_rst,
   input  logic [Ma-1:0] FCi,
   input  logic [Ma-1:0] Fi,
   output logic [M-1:0]  Ii,
   input  logic          fc_finish,
   input  logic          result_ack,
   output logic [7:0]    frames_done
);

   localparam int D    = N_f * S_P_o * S_P_o;
   localparam int AW   = $clog2(D);
   localparam int RW   = 2 * Ma;

   localparam logic [Ma-1:0] LAST_ADDR = Ma'(D - 1);
   localparam logic [Ma-1:0] ROWS_MA   = Ma'(S_P_o * S_P_o);
   localparam logic [Ma-1:0] COLS_MA   = Ma'(N_f);
   localparam logic [RW-1:0] ROWS_RW   = RW'(S_P_o * S_P_o);
   localparam logic [RW-1:0] DEPTH_RW  = RW'(D);

   fc_state_e       state_q, state_d;
   logic [Ma-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]      frames_q, frames_d;

   logic            wr_en;
   logic [RW-1:0]   rd_addr;
   logic            rd_in_range;
   logic [M-1:0]    ram_rdata;

   // Handshake: a pool word transfers on a rising edge where pool_valid and
   // pool_ready are both high; pool_ready comes from the state register only.
   assign pool_ready = (state_q == FILL);
   assign fc_rst     = (state_q == FILL);
   assign wr_en      = pool_valid && (state_q == FILL);

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      frames_d  = frames_q;
      case (state_q)
         FILL: begin
            if (wr_en) begin
               if (wr_addr_q == LAST_ADDR) begin
                  wr_addr_d = '0;
                  state_d   = SERVE;
               end else begin
                  wr_addr_d = wr_addr_q + 1'b1;
               end
            end
         end
         SERVE: begin
            // finish alone holds the frame; ack alone is meaningless
            if (fc_finish && result_ack) begin
               state_d  = FILL;
               frames_d = frames_q + 8'd1;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FILL;
         wr_addr_q <= '0;
         frames_q  <= '0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         frames_q  <= frames_d;
      end
   end

   // Full 2*Ma width so an oversized Fi cannot wrap back into range.
   assign rd_addr     = ({{Ma{1'b0}}, Fi} * ROWS_RW) + {{Ma{1'b0}}, FCi};
   assign rd_in_range = (FCi < ROWS_MA) && (Fi < COLS_MA) && (rd_addr < DEPTH_RW);

   fc_fmap_ram #(
      .W     (M),
      .DEPTH (D),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr_q[AW-1:0]),
      .wdata (pool_data),
      .raddr (rd_addr[AW-1:0]),
      .rdata (ram_rdata)
   );

   assign Ii          = ((state_q == SERVE) && rd_in_range) ? ram_rdata : '0;
   assign frames_done = frames_q;

endmodule : fc_feed

// File: tb/tb_fc_feed.sv
// Randomized self-checking bench for fc_feed against a frame-level model.
module tb_fc_feed;

   localparam int ROWS = 16;
   localparam int COLS = 12;
   localparam int D    = ROWS * COLS;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pool_valid = 1'b0;
   logic [31:0] pool_data = '0;
   logic        pool_ready;
   logic        fc_rst;
   logic [15:0] FCi = '0;
   logic [15:0] Fi = '0;
   logic [31:0] Ii;
   logic        fc_finish = 1'b0;
   logic        result_ack = 1'b0;
   logic [7:0]  frames_done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: last word written to each flat position, whether a
   // complete frame is currently being served, and frames acknowledged.
   logic [31:0] exp_mem [D];
   bit          exp_serving = 1'b0;
   int          exp_frames = 0;

   fc_feed dut (
      .clk         (clk),
      .rst         (rst),
      .pool_valid  (pool_valid),
      .pool_data   (pool_data),
      .pool_ready  (pool_ready),
      .fc_rst      (fc_rst),
      .FCi         (FCi),
      .Fi          (Fi),
      .Ii          (Ii),
      .fc_finish   (fc_finish),
      .result_ack  (result_ack),
      .frames_done (frames_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", tag, act, act, exp, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_pool_ready", {31'd0, pool_ready}, 32'd1);
      check("rst_fc_rst", {31'd0, fc_rst}, 32'd1);
      check("rst_frames", {24'd0, frames_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_serving = 1'b0;
      exp_frames  = 0;
   endtask

   function automatic logic [31:0] model_ii(input int fci, input int fi);
      if (!exp_serving || fci >= ROWS || fi >= COLS) return 32'd0;
      return exp_mem[fi * ROWS + fci];
   endfunction

   // mode 0: valid every cycle, 1: every other cycle, 2: random
   task automatic stream(input int base, input int mode, input int n);
      int idx = 0;
      int cyc = 0;
      bit v;
      while (idx < n && cyc < 5000) begin
         @(negedge clk);
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = 1'($urandom_range(0, 1));
         endcase
         pool_valid = v;
         pool_data  = 32'(base + idx);
         @(posedge clk);
         if (v) begin
            exp_mem[idx] = 32'(base + idx);
            idx++;
         end
         cyc++;
      end
      if (idx < n) check("stream_timeout", 32'(idx), 32'(n));
      if (n == D) exp_serving = 1'b1;
      @(negedge clk);
      pool_valid = 1'b0;
   endtask

   task automatic read_chk(input string tag, input int fci, input int fi);
      @(negedge clk);
      FCi = 16'(fci);
      Fi  = 16'(fi);
      #1;
      check(tag, Ii, model_ii(fci, fi));
   endtask

   task automatic finish_ack(input int hold);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         fc_finish  = 1'b1;
         result_ack = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      fc_finish  = 1'b1;
      result_ack = 1'b1;
      @(posedge clk);
      exp_frames  = (exp_frames + 1) % 256;
      exp_serving = 1'b0;
      @(negedge clk);
      fc_finish  = 1'b0;
      result_ack = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < D; i++) exp_mem[i] = '0;

      do_reset();
      check("reset_ii", Ii, 32'd0);

      // Frame 1: continuous stream of 0..191
      stream(0, 0, D);
      #1;
      check("f1_ready_low", {31'd0, pool_ready}, 32'd0);
      check("f1_fc_rst_low", {31'd0, fc_rst}, 32'd0);
      check("f1_read_0_0", Ii, model_ii(0, 0));
      read_chk("f1_read_3_2", 3, 2);
      check("f1_fixed_35", Ii, 32'd35);
      read_chk("f1_row_oob", 16, 0);
      read_chk("f1_col_oob", 0, 12);
      read_chk("f1_big_oob", 16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 8; i++)
         read_chk("f1_rand_read", $urandom_range(0, 17), $urandom_range(0, 13));

      // fc_finish without ack must hold the frame
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         fc_finish = 1'b1;
         #1;
         check("hold_ready", {31'd0, pool_ready}, 32'd0);
         check("hold_frames", {24'd0, frames_done}, 32'd0);
      end
      FCi = 16'd7; Fi = 16'd5;
      #1;
      check("hold_ii", Ii, model_ii(7, 5));
      @(negedge clk);
      fc_finish  = 1'b0;
      result_ack = 1'b1;
      @(negedge clk);
      #1;
      check("ack_only_ignored", {31'd0, fc_rst}, 32'd0);
      result_ack = 1'b0;
      finish_ack(0);
      #1;
      check("ack_fc_rst", {31'd0, fc_rst}, 32'd1);
      check("ack_ready", {31'd0, pool_ready}, 32'd1);
      check("ack_frames", {24'd0, frames_done}, 32'(exp_frames));
      read_chk("fill_ii_zero", 1, 1);

      // Frame 2: toggling valid, then pool_valid in SERVE must not write
      stream(500, 1, D);
      read_chk("f2_read_15_11", 15, 11);
      check("f2_fixed", Ii, 32'd691);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pool_valid = 1'b1;
         pool_data  = 32'hDEAD_0000 + 32'(i);
      end
      @(negedge clk);
      pool_valid = 1'b0;
      read_chk("serve_no_write_0", 0, 0);
      read_chk("serve_no_write_1", 1, 0);
      for (int i = 0; i < 6; i++)
         read_chk("f2_rand_read", $urandom_range(0, 15), $urandom_range(0, 11));

      // Async reset while serving clears everything immediately
      check("pre_rst_frames", {24'd0, frames_done}, 32'd1);
      #2;
      do_reset();

      // Random-valid partial frame, then async reset mid-fill
      stream(2000, 2, 100);
      @(negedge clk);
      #3;
      do_reset();
      stream(1000, 2, D);
      read_chk("f3_read_0_0", 0, 0);
      check("f3_fixed", Ii, 32'd1000);
      for (int i = 0; i < 10; i++)
         read_chk("f3_rand_read", $urandom_range(0, 15), $urandom_range(0, 11));
      finish_ack($urandom_range(0, 3));
      #1;
      check("f3_frames", {24'd0, frames_done}, 32'(exp_frames));

      // 255 further frames: counter wraps back to zero
      for (int f = 0; f < 255; f++) begin
         stream(f * 7 + 3, 0, D);
         read_chk("bulk_read", $urandom_range(0, 15), $urandom_range(0, 11));
         finish_ack(0);
         if (f % 32 == 0 || f >= 253) begin
            #1;
            check("bulk_frames", {24'd0, frames_done}, 32'(exp_frames));
         end
      end
      #1;
      check("wrap_zero", {24'd0, frames_done}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fc_feed
